// File: rtl/ycr_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ycr_div_pkg
//  Brief    : Shared state encodings and parameter-legality constants for the
//             iterative divider.
//  Revision : 1.0 - initial release
// ============================================================================
package ycr_div_pkg;

    localparam logic [2:0] C_ST_IDLE = 3'd0;
    localparam logic [2:0] C_ST_PREP = 3'd1;
    localparam logic [2:0] C_ST_CALC = 3'd2;
    localparam logic [2:0] C_ST_FIX  = 3'd3;
    localparam logic [2:0] C_ST_OUT  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = C_ST_IDLE,
        ST_PREP = C_ST_PREP,
        ST_CALC = C_ST_CALC,
        ST_FIX  = C_ST_FIX,
        ST_OUT  = C_ST_OUT
    } div_state_t;

    // Bit n set means n quotient bits per cycle is a supported setting.
    localparam logic [7:0] C_BPC_LEGAL_MASK = 8'b0001_0110;

endpackage
`default_nettype wire

// File: rtl/ycr_div_step.sv
`default_nettype none
// ============================================================================
//  Module   : ycr_div_step
//  Brief    : One radix-2 restoring compare/subtract stage.
//  Revision : 1.0 - initial release
// ============================================================================
module ycr_div_step #(
    parameter int DW = 32
) (
    input  logic [DW:0]   i_rem,
    input  logic [DW-1:0] i_div,
    output logic          o_qbit,
    output logic [DW-1:0] o_rem
);

    // i_rem carries one guard bit above the divisor width; the restored or
    // subtracted result always fits back in DW bits because it is < divisor.
    assign o_qbit = (i_rem >= {1'b0, i_div});
    assign o_rem  = o_qbit ? (i_rem[DW-1:0] - i_div) : i_rem[DW-1:0];

endmodule
`default_nettype wire

// File: rtl/ycr_div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : ycr_div_iter
//  Brief    : Iterative signed/unsigned restoring divider, BPC bits per cycle.
//             Optional macro YCR_DIV_EARLY_EXIT_EN skips leading-zero groups.
//  Revision : 1.0 - initial release
// ============================================================================
module ycr_div_iter
    import ycr_div_pkg::*;
#(
    parameter int DW  = 32,
    parameter int BPC = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          signed_i,
    input  logic [DW-1:0] dividend_i,
    input  logic [DW-1:0] divisor_i,
    output logic          res_valid_o,
    input  logic          res_ready_i,
    output logic [DW-1:0] quotient_o,
    output logic [DW-1:0] remainder_o,
    output logic          divz_o
);

    localparam int K  = DW / BPC;
    localparam int CW = $clog2(K + 1);

    generate
        if ((((C_BPC_LEGAL_MASK >> BPC) & 8'd1) == 8'd0) || ((DW % BPC) != 0) ||
            (DW < 8) || ((DW % 2) != 0)) begin : g_bad_param
            $error("ycr_div_iter: illegal DW/BPC combination");
        end
    endgenerate

    div_state_t    r_state;
    logic          r_sgn;
    logic [DW-1:0] r_dvd;
    logic [DW-1:0] r_dvs;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_rem;
    logic [CW-1:0] r_cnt;
    logic          r_neg_q;
    logic          r_neg_r;
    logic          r_divz;

    logic [DW-1:0] w_abs_a;
    logic [DW-1:0] w_abs_b;
    logic [CW-1:0] w_skip;
    logic [DW-1:0] w_rem [0:BPC];
    logic [DW-1:0] w_a   [0:BPC];

    assign req_ready_o = (r_state == ST_IDLE);

    assign w_abs_a = (r_sgn && r_dvd[DW-1]) ? -r_dvd : r_dvd;
    assign w_abs_b = (r_sgn && r_dvs[DW-1]) ? -r_dvs : r_dvs;

`ifdef YCR_DIV_EARLY_EXIT_EN
    // Largest step count whose leading BPC-bit groups of |a| are all zero.
    always_comb begin
        w_skip = '0;
        for (int i = 1; i < K; i++) begin
            if ((w_abs_a >> (DW - i * BPC)) == '0) begin
                w_skip = CW'(i);
            end
        end
    end
`else
    assign w_skip = '0;
`endif

    // r_a doubles as dividend shifter and quotient collector.
    assign w_rem[0] = r_rem;
    assign w_a[0]   = r_a;

    generate
        for (genvar j = 0; j < BPC; j++) begin : g_step
            logic w_qbit;
            ycr_div_step #(.DW(DW)) u_step (
                .i_rem  ({w_rem[j], w_a[j][DW-1]}),
                .i_div  (r_b),
                .o_qbit (w_qbit),
                .o_rem  (w_rem[j+1])
            );
            assign w_a[j+1] = {w_a[j][DW-2:0], w_qbit};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sgn       <= 1'b0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_divz      <= 1'b0;
            res_valid_o <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            divz_o      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_sgn   <= signed_i;
                        r_dvd   <= dividend_i;
                        r_dvs   <= divisor_i;
                        r_state <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    r_a     <= w_abs_a << (int'(w_skip) * BPC);
                    r_b     <= w_abs_b;
                    r_rem   <= '0;
                    r_cnt   <= CW'(K - 1) - w_skip;
                    r_neg_q <= r_sgn & (r_dvd[DW-1] ^ r_dvs[DW-1]);
                    r_neg_r <= r_sgn & r_dvd[DW-1];
                    r_divz  <= (r_dvs == '0);
                    r_state <= (r_dvs == '0) ? ST_FIX : ST_CALC;
                end
                ST_CALC: begin
                    r_a   <= w_a[BPC];
                    r_rem <= w_rem[BPC];
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    // Divide-by-zero returns the raw dividend, never sign-fixed.
                    if (r_divz) begin
                        quotient_o  <= '1;
                        remainder_o <= r_dvd;
                        divz_o      <= 1'b1;
                    end else begin
                        quotient_o  <= r_neg_q ? -r_a : r_a;
                        remainder_o <= r_neg_r ? -r_rem : r_rem;
                        divz_o      <= 1'b0;
                    end
                    res_valid_o <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ycr_div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ycr_div_iter
//  Brief    : Directed/random scoreboard bench for ycr_div_iter (DW=32, BPC=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ycr_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;
    logic        divz_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    ycr_div_iter #(.DW(32), .BPC(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .divz_o      (divz_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz);
        dz = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int exp_lat(input bit s, input logic [31:0] a, input logic [31:0] b);
`ifdef YCR_DIV_EARLY_EXIT_EN
        logic [31:0] m;
        int lz;
        int sk;
`endif
        if (b == 32'd0) return 2;
`ifdef YCR_DIV_EARLY_EXIT_EN
        m  = (s && a[31]) ? (~a + 32'd1) : a;
        lz = 0;
        while (lz < 32 && m[31 - lz] == 1'b0) lz++;
        sk = lz / 2;
        if (sk > 15) sk = 15;
        return 16 - sk + 2;
`else
        return 18;
`endif
    endfunction

    // Drive one request, wait for acceptance, push the expectation, then
    // scramble the inputs so in-flight isolation is exercised.
    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        int   n = 0;
        req_valid_i = 1'b1; signed_i = s; dividend_i = a; divisor_i = b;
        while (req_ready_o !== 1'b1 && n < 100) begin
            @(negedge clk); n++;
        end
        if (n >= 100) chk("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        req_valid_i = 1'b0;
        signed_i    = ~s;
        dividend_i  = $urandom;
        divisor_i   = $urandom;
        if (push) begin
            model(s, a, b, e.q, e.r, e.dz);
            e.acc = cyc;
            e.lat = exp_lat(s, a, b);
            sb.push_back(e);
        end
    endtask

    task automatic collect(input string tag);
        exp_t e;
        int   n = 0;
        while (res_valid_o !== 1'b1 && n < 200) begin
            @(negedge clk); n++;
        end
        chk({tag, "_valid"}, {31'd0, res_valid_o}, 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
            chk({tag, "_q"}, quotient_o, e.q);
            chk({tag, "_r"}, remainder_o, e.r);
            chk({tag, "_dz"}, {31'd0, divz_o}, {31'd0, e.dz});
        end
    endtask

    task automatic run_op(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b);
        issue(s, a, b, 1'b1);
        collect(tag);
    endtask

    initial begin
        logic [31:0] hq;
        logic [31:0] hr;
        int          seen;

        rst = 1'b1; req_valid_i = 1'b0; signed_i = 1'b0;
        dividend_i = '0; divisor_i = '0; res_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_valid", {31'd0, res_valid_o}, 32'd0);
        chk("rst_q", quotient_o, 32'd0);
        chk("rst_r", remainder_o, 32'd0);
        chk("rst_dz", {31'd0, divz_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("u100_7", 1'b0, 32'd100, 32'd7);
        run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2);
        run_op("divz", 1'b0, 32'h0000_1234, 32'd0);
        run_op("divz_sneg", 1'b1, 32'hFFFF_FF00, 32'd0);
        run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_op("u5_3", 1'b0, 32'd5, 32'd3);
        run_op("uff_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        run_op("u_small_big", 1'b0, 32'd3, 32'hFFFF_FFF0);

        // Back-pressure: result must hold while res_ready_i is low.
        @(negedge clk);
        res_ready_i = 1'b0;
        issue(1'b0, 32'd1000, 32'd3, 1'b1);
        collect("bp");
        hq = quotient_o; hr = remainder_o;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'd0, res_valid_o}, 32'd1);
            chk("bp_hold_ready", {31'd0, req_ready_o}, 32'd0);
            chk("bp_hold_q", quotient_o, 32'd333);
            chk("bp_hold_r", remainder_o, 32'd1);
        end
        res_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_ready_after", {31'd0, req_ready_o}, 32'd1);
        chk("bp_valid_after", {31'd0, res_valid_o}, 32'd0);
        chk("idle_keep_q", quotient_o, hq);
        chk("idle_keep_r", remainder_o, hr);
        run_op("b2b", 1'b1, 32'hFFFF_F000, 32'd9);

        // Reset during the eighth CALC cycle discards the operation.
        @(negedge clk);
        @(negedge clk);
        issue(1'b0, 32'hDEAD_BEEF, 32'd17, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_q", quotient_o, 32'd0);
        chk("mid_rst_r", remainder_o, 32'd0);
        chk("mid_rst_dz", {31'd0, divz_o}, 32'd0);
        chk("mid_rst_valid", {31'd0, res_valid_o}, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready_o}, 32'd1);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (res_valid_o === 1'b1) seen++;
        end
        chk("mid_rst_no_result", 32'(seen), 32'd0);

        run_op("post_rst", 1'b0, 32'd100, 32'd7);
        for (int i = 0; i < 8; i++) begin
            bit          s;
            logic [31:0] a;
            logic [31:0] b;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (i == 0) b = 32'hFFFF_FFFD;
            run_op("rand", s, a, b);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
